ps2_matrix_kbd: RTL

Parametrised PS/2-to-keyboard-matrix converter with a run-time loadable scancode map, an event FIFO and a minimum-hold pacer. It sits between the HPS PS/2 key stream and the emulated CPU's keyboard port. It replaces a hard-coded mapping with a 512-entry map RAM. Every key state change is held for a guaranteed number of cycles, so a fast press/release pair is never lost between CPU scans.

---
 rtl/ps2_matrix_kbd.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd: converts the PS/2 key event stream into an emulated keyboard matrix,
// using a loadable scancode map, an event FIFO and a minimum-hold pacer between changes.
module ps2_matrix_kbd #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 4096,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [10:0]       ps2_key,
    input  logic              map_we,
    input  logic [8:0]        map_addr,
    input  logic [RW+CW:0]    map_wdata,
    input  logic [ROWS-1:0]   addr,
    output logic [COLS-1:0]   kb_cols,
    output logic              overflow,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
    localparam logic [RW:0]   ROW_LIMIT = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COL_LIMIT = (CW + 1)'(COLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_APPLY,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_prevToggle;
    logic              w_event;
    logic              w_fifoFull;
    logic              w_push;
    logic              w_pop;
    logic [9:0]        r_fifoMem [FIFO_DEPTH];
    logic [9:0]        w_fifoHead;
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [NW-1:0]     r_fifoCount;
    logic              r_overflow;
    logic [RW+CW:0]    r_mapMem [512];
    logic [RW+CW:0]    r_mapRdata;
    logic              r_pressed;
    logic [RW-1:0]     w_entryRow;
    logic [CW-1:0]     w_entryCol;
    logic              w_entryValid;
    logic [HW-1:0]     r_holdCnt;
    logic [COLS-1:0]   r_matrix [ROWS];
    logic [COLS-1:0]   w_cols;

    assign w_event    = (ps2_key[10] != r_prevToggle);
    assign w_fifoFull = (r_fifoCount == FIFO_FULL);
    assign w_push     = w_event && !w_fifoFull && !reset;
    assign w_fifoHead = r_fifoMem[r_rdPtr];

    assign w_entryRow   = r_mapRdata[RW+CW-1:CW];
    assign w_entryCol   = r_mapRdata[CW-1:0];
    assign w_entryValid = r_mapRdata[RW+CW]
                          && ({1'b0, w_entryRow} < ROW_LIMIT)
                          && ({1'b0, w_entryCol} < COL_LIMIT);

    // The toggle tracker keeps loading during reset so a toggle seen then is not an event.
    always_ff @(posedge clk_sys) begin
        r_prevToggle <= ps2_key[10];
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_event && w_fifoFull) begin
                r_overflow <= 1'b1;
            end
            r_fifoCount <= r_fifoCount + NW'(w_push) - NW'(w_pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= ps2_key[9:0];
        end
    end

    // Map contents survive reset; a same-edge write leaves the read with the old entry.
    always_ff @(posedge clk_sys) begin
        if (map_we) begin
            r_mapMem[map_addr] <= map_wdata;
        end
        if (w_pop) begin
            r_mapRdata <= r_mapMem[w_fifoHead[8:0]];
            r_pressed  <= w_fifoHead[9];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_fifoCount != '0) begin
                    w_pop       = 1'b1;
                    w_nextState = S_READ;
                end
            end
            S_READ:  w_nextState = S_APPLY;
            S_APPLY: w_nextState = (w_entryValid && HOLD_EN) ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (r_holdCnt == HOLD_LAST) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_holdCnt <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_matrix[r] <= '1;
            end
        end else if (r_state == S_APPLY) begin
            r_holdCnt <= '0;
            if (w_entryValid) begin
                r_matrix[w_entryRow][w_entryCol] <= ~r_pressed;
            end
        end else if (r_state == S_HOLD) begin
            r_holdCnt <= r_holdCnt + HW'(1);
        end
    end

    // Selected rows are wire-ANDed, so any pressed key in any selected row pulls its column low.
    always_comb begin
        w_cols = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!addr[r]) begin
                w_cols = w_cols & r_matrix[r];
            end
        end
    end

    assign kb_cols  = w_cols;
    assign overflow = r_overflow;
    assign busy     = (r_fifoCount != '0) || (r_state != S_IDLE);

endmodule
